// File: rtl/sumador_pkg.sv
// Shared definitions for the sumador_ctrl operand-entry / display controller.
//   - FSM state encoding (state_t)
//   - digit index constants used by the display scan
//   - blank anode pattern and a helper that builds the active-low digit enable
package sumador_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_GOT_B = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  localparam logic [1:0] IDX_SUM  = 2'd0;
  localparam logic [1:0] IDX_COUT = 2'd1;
  localparam logic [1:0] IDX_B    = 2'd2;
  localparam logic [1:0] IDX_A    = 2'd3;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Active-low one-hot-zero enable for the scanned digit.
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sumador_ctrl_if.sv
// Board / adder side bundle of sumador_ctrl.
//   sw, sw_cin          : switch operand value and carry-in
//   btn_load, btn_clear : raw (unsynchronised) button levels
//   s, cout4            : combinational result from the external 4-bit adder
//   a, b, cin           : operand registers driven to the adder
//   valid               : high while a latched result is shown
//   bcd, an             : nibble and active-low digit enables for the 7-seg decoder
// modport master = the controller, modport slave = board I/O plus adder.
interface sumador_ctrl_if;
  logic [3:0] sw;
  logic       sw_cin;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] s;
  logic       cout4;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       valid;
  logic [3:0] bcd;
  logic [3:0] an;

  modport master (
    input  sw, sw_cin, btn_load, btn_clear, s, cout4,
    output a, b, cin, valid, bcd, an
  );

  modport slave (
    output sw, sw_cin, btn_load, btn_clear, s, cout4,
    input  a, b, cin, valid, bcd, an
  );
endinterface

// File: rtl/display_mux.sv
// Time-multiplexed scan of the 4-digit 7-segment display.
//   clk, rst      : clock, asynchronous active-high reset
//   a, b          : operands (digits 3 and 2)
//   sum_r, cout_r : result nibble and carry (digits 0 and 1)
//   blank         : force all digits off and bcd to 0
//   bcd, an       : registered nibble and active-low digit enables
// The refresh counter and digit index run continuously, even while blanked,
// so each digit is lit for exactly REFRESH_DIV cycles.
module display_mux
  import sumador_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sum_r,
  input  logic       cout_r,
  input  logic       blank,
  output logic [3:0] bcd,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    digit_next;

  always_comb begin
    digit_next = '0;
    case (idx_reg)
      IDX_SUM:  digit_next = sum_r;
      IDX_COUT: digit_next = {3'b000, cout_r};
      IDX_B:    digit_next = b;
      IDX_A:    digit_next = a;
      default:  digit_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      bcd     <= '0;
      an      <= AN_BLANK;
    end else begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      // an and bcd move together so a digit never shows its neighbour's value.
      if (blank) begin
        an  <= AN_BLANK;
        bcd <= '0;
      end else begin
        an  <= digit_enable(idx_reg);
        bcd <= digit_next;
      end
    end
  end

endmodule

// File: rtl/sumador_ctrl.sv
// Operand-entry and display controller for the 4-bit adder lab.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sumador_ctrl_if.master (switches, buttons, adder result,
//              operand registers, valid, bcd/an display drive)
// Each button goes through a 2-FF synchroniser plus one edge FF, giving a
// single-cycle pulse per press. The FSM captures A, then B/cin, waits one
// cycle for the external adder to settle, then latches {cout, sum}.
module sumador_ctrl
  import sumador_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst,
  sumador_ctrl_if.master bus
);

  // bit 0 = load, bit 1 = clear
  logic [1:0] btn;
  logic [1:0] pulse;
  logic       load_p;
  logic       clear_p;

  assign btn = {bus.btn_clear, bus.btn_load};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      // [0],[1] synchroniser stages, [2] previous synchronised level
      logic [2:0] sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_reg <= '0;
        else     sync_reg <= {sync_reg[1:0], btn[gi]};
      end
      assign pulse[gi] = sync_reg[1] & ~sync_reg[2];
    end
  endgenerate

  assign load_p  = pulse[0];
  assign clear_p = pulse[1];

  state_t     state_reg, state_next;
  logic [3:0] a_reg, a_next;
  logic [3:0] b_reg, b_next;
  logic       cin_reg, cin_next;
  logic [3:0] sum_reg, sum_next;
  logic       cout_reg, cout_next;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cin_next   = cin_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    if (clear_p) begin
      // clear takes priority over a coincident load
      state_next = S_IDLE;
      a_next     = '0;
      b_next     = '0;
      cin_next   = 1'b0;
      sum_next   = '0;
      cout_next  = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (load_p) begin
          a_next     = bus.sw;
          state_next = S_GOT_A;
        end
        S_GOT_A: if (load_p) begin
          b_next     = bus.sw;
          cin_next   = bus.sw_cin;
          state_next = S_GOT_B;
        end
        S_GOT_B: begin
          // operands have been stable for a full cycle; load_p is ignored here
          sum_next   = bus.s;
          cout_next  = bus.cout4;
          state_next = S_SHOW;
        end
        S_SHOW: if (load_p) begin
          a_next     = bus.sw;
          state_next = S_GOT_A;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cin_reg   <= cin_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  assign bus.a     = a_reg;
  assign bus.b     = b_reg;
  assign bus.cin   = cin_reg;
  assign bus.valid = (state_reg == S_SHOW);

  // A stale result from the previous operation stays in sum_reg/cout_reg
  // until the next latch; only show it while it is the current result.
  logic [3:0] sum_disp;
  logic       cout_disp;
  assign sum_disp  = bus.valid ? sum_reg : 4'd0;
  assign cout_disp = bus.valid & cout_reg;

  display_mux #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_display (
    .clk    (clk),
    .rst    (rst),
    .a      (a_reg),
    .b      (b_reg),
    .sum_r  (sum_disp),
    .cout_r (cout_disp),
    .blank  (state_reg == S_IDLE),
    .bcd    (bus.bcd),
    .an     (bus.an)
  );

endmodule

// File: tb/tb_sumador_ctrl.sv
// Bench for sumador_ctrl with REFRESH_DIV=4. The lab adder is stood in for by
// a continuous assignment. A behavioural model of the operand-entry flow and
// display scan is checked against the DUT on every clock; directed sequences
// add literal expectations for results, scan order and reset behaviour.
module tb_sumador_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sumador_ctrl_if bus();

  sumador_ctrl #(
    .REFRESH_DIV(DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stand-in for sumador4bit
  logic [4:0] add5;
  assign add5      = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0000, bus.cin};
  assign bus.s     = add5[3:0];
  assign bus.cout4 = add5[4];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: how far the current operation has progressed
  //   0 nothing entered, 1 A entered, 2 B entered (adding), 3 result shown
  int         m_phase;
  logic [3:0] m_a, m_b, m_sum;
  logic       m_cin, m_cout;
  int         m_cnt, m_idx;
  logic [2:0] hl, hc;      // button samples: [0] last edge, [1] two edges ago, [2] three
  logic [3:0] e_an, e_bcd;

  always @(posedge clk) begin
    logic       lp, cp;
    logic [3:0] dig [4];
    logic [4:0] tot;
    if (rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_cin = 0; m_sum = 0; m_cout = 0;
      m_cnt = 0; m_idx = 0; hl = 0; hc = 0;
      e_an = 4'hF; e_bcd = 4'h0;
    end else begin
      dig[0] = (m_phase == 3) ? m_sum : 4'h0;
      dig[1] = (m_phase == 3) ? {3'b000, m_cout} : 4'h0;
      dig[2] = m_b;
      dig[3] = m_a;
      e_an = 4'hF;
      e_bcd = 4'h0;
      if (m_phase != 0) begin
        e_an[m_idx] = 1'b0;
        e_bcd = dig[m_idx];
      end
      // a press is seen once its level has crossed the 2-stage synchroniser
      lp = hl[1] & ~hl[2];
      cp = hc[1] & ~hc[2];
      hl = {hl[1:0], bus.btn_load};
      hc = {hc[1:0], bus.btn_clear};
      if (cp) begin
        m_phase = 0; m_a = 0; m_b = 0; m_cin = 0; m_sum = 0; m_cout = 0;
      end else if (m_phase == 2) begin
        tot = m_a + m_b + m_cin;
        m_sum = tot[3:0];
        m_cout = tot[4];
        m_phase = 3;
      end else if (lp && m_phase == 1) begin
        m_b = bus.sw; m_cin = bus.sw_cin; m_phase = 2;
      end else if (lp) begin
        m_a = bus.sw; m_phase = 1;
      end
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end
    end
    #1;
    chk("a",     bus.a,     m_a);
    chk("b",     bus.b,     m_b);
    chk("cin",   bus.cin,   m_cin);
    chk("valid", bus.valid, (m_phase == 3));
    chk("an",    bus.an,    e_an);
    chk("bcd",   bus.bcd,   e_bcd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic ld, input logic cl, input logic [3:0] v,
                       input logic ci, input int hold, input int gap);
    @(negedge clk);
    bus.sw = v; bus.sw_cin = ci; bus.btn_load = ld; bus.btn_clear = cl;
    repeat (hold) @(negedge clk);
    bus.btn_load = 1'b0; bus.btn_clear = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    while (bus.an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_found"}, bus.an, target);
  endtask

  // full operation with literal result expectations
  task automatic op(input logic [3:0] va, input logic [3:0] vb, input logic ci,
                    input logic [3:0] exp_sum, input logic exp_cout, input string name);
    press(1'b1, 1'b0, va, 1'b0, 1, 3);
    chk({name, "_a"}, bus.a, va);
    press(1'b1, 1'b0, vb, ci, 1, 2);   // now one cycle after B capture edge
    chk({name, "_b"}, bus.b, vb);
    chk({name, "_valid_pre"}, bus.valid, 1'b0);
    @(negedge clk);
    chk({name, "_valid"}, bus.valid, 1'b1);
    wait_an(4'b1110, {name, "_d0"});
    chk({name, "_sum"}, bus.bcd, exp_sum);
    wait_an(4'b1101, {name, "_d1"});
    chk({name, "_cout"}, bus.bcd, {3'b000, exp_cout});
  endtask

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] scan_bcd [4] = '{4'hF, 4'h0, 4'hA, 4'h5};

  initial begin
    logic [3:0] prev;
    bit         found;
    int         r;
    bus.sw = 0; bus.sw_cin = 0; bus.btn_load = 0; bus.btn_clear = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    repeat (20) @(negedge clk);
    chk("idle_an", bus.an, 4'b1111);
    chk("idle_bcd", bus.bcd, 4'h0);
    chk("idle_valid", bus.valid, 1'b0);
    chk("idle_a", bus.a, 4'h0);
    chk("idle_b", bus.b, 4'h0);

    op(4'd2,  4'd3,  1'b0, 4'b0101, 1'b0, "add_2_3");
    op(4'd15, 4'd1,  1'b0, 4'b0000, 1'b1, "add_15_1");
    op(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, "add_15_15_c");
    op(4'd12, 4'd3,  1'b0, 4'b1111, 1'b0, "add_12_3");

    // clear from SHOW
    press(1'b0, 1'b1, 4'd0, 1'b0, 1, 3);
    chk("clr_a", bus.a, 4'h0);
    chk("clr_valid", bus.valid, 1'b0);
    chk("clr_an", bus.an, 4'b1111);

    // long hold in IDLE gives exactly one capture
    press(1'b1, 1'b0, 4'd7, 1'b0, 50, 3);
    chk("hold_a", bus.a, 4'd7);
    chk("hold_b", bus.b, 4'd0);
    chk("hold_valid", bus.valid, 1'b0);
    chk("hold_lit", (bus.an == 4'b1111), 1'b0);

    // clear and load together: clear wins
    press(1'b1, 1'b1, 4'd9, 1'b1, 2, 3);
    chk("both_a", bus.a, 4'd0);
    chk("both_b", bus.b, 4'd0);
    chk("both_an", bus.an, 4'b1111);

    // scan order and dwell with a=5, b=10
    op(4'd5, 4'd10, 1'b0, 4'hF, 1'b0, "add_5_10");
    prev = bus.an;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && bus.an == 4'b1110) found = 1'b1;
      prev = bus.an;
    end
    chk("scan_start", found, 1'b1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DIV; c++) begin
        if (d != 0 || c != 0) @(negedge clk);
        chk("scan_an", bus.an, scan_an[d]);
        chk("scan_bcd", bus.bcd, scan_bcd[d]);
      end
    end
    @(negedge clk);
    chk("scan_wrap", bus.an, 4'b1110);

    // reset asserted while in GOT_B
    press(1'b1, 1'b0, 4'd4, 1'b0, 1, 3);
    @(negedge clk);
    bus.sw = 4'd6; bus.sw_cin = 1'b1; bus.btn_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.btn_load = 1'b0;
    @(posedge clk);
    @(posedge clk);          // B capture edge
    #1;
    chk("gotb_b", bus.b, 4'd6);
    chk("gotb_valid", bus.valid, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_an", bus.an, 4'b1111);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_a", bus.a, 4'd0);
    chk("rst_b", bus.b, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", bus.valid, 1'b0);
    press(1'b1, 1'b0, 4'd9, 1'b0, 1, 3);
    chk("post_rst_a", bus.a, 4'd9);
    chk("post_rst_b", bus.b, 4'd0);

    // randomized presses, checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      press(r != 0, r <= 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 4), $urandom_range(0, 4));
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
